// File: rtl/fir_ctrl_pkg.sv
// Shared types and constants for the FIR coefficient controller.
//   fir_ctrl_state_e : controller states (IDLE, DRAIN, SWAP)
//   coef_t           : signed coefficient at the default width
//   GEN_W            : width of the active-bank generation counter
package fir_ctrl_pkg;

    localparam int COEF_W_DFLT = 16;
    localparam int GEN_W       = 8;

    typedef logic signed [COEF_W_DFLT-1:0] coef_t;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        SWAP
    } fir_ctrl_state_e;

endpackage

// File: rtl/fir_coef_bank.sv
// Shadow/active coefficient register banks.
//   clk, rst        : clock, synchronous active-high reset (clears both banks)
//   wr_en/addr/data : shadow write port; out-of-range addresses are dropped
//   load            : copy the whole shadow bank into the active bank
//   coef            : active bank, packed, tap k at [k*COEF_W +: COEF_W]
module fir_coef_bank
    import fir_ctrl_pkg::*;
#(
    parameter int N_TAPS = 16,
    parameter int COEF_W = 16,
    parameter int ADDR_W = $clog2(N_TAPS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [COEF_W-1:0]          wr_data,
    input  logic                       load,
    output logic [N_TAPS*COEF_W-1:0]   coef
);

    logic [COEF_W-1:0] shadow [N_TAPS];
    logic [COEF_W-1:0] active [N_TAPS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < N_TAPS; k++) begin
                shadow[k] <= '0;
                active[k] <= '0;
            end
        end else begin
            if (wr_en && (int'({1'b0, wr_addr}) < N_TAPS)) begin
                shadow[wr_addr] <= wr_data;
            end
            if (load) begin
                for (int unsigned k = 0; k < N_TAPS; k++) begin
                    active[k] <= shadow[k];
                end
            end
        end
    end

    for (genvar k = 0; k < N_TAPS; k++) begin : g_pack
        assign coef[k*COEF_W +: COEF_W] = active[k];
    end

endmodule

// File: rtl/fir_coef_ctrl.sv
// Coefficient-bank controller and input-stream sequencer for fir_filter.
// A commit stalls the input stream, waits for the FIR pipeline to drain and
// for any held output to be taken, then swaps shadow into active in one cycle.
//   clk, rst                 : clock, synchronous active-high reset
//   i_cfg_wr/addr/data       : host shadow write port
//   i_cfg_commit             : request shadow->active swap
//   o_cfg_busy/err/done      : commit in progress / rejected request / swap pulse
//   o_coef_gen               : active-bank generation counter (wraps)
//   i_s_valid, o_s_ready     : upstream sample handshake
//   o_fir_valid, i_fir_ready : fir_filter input handshake
//   i_fir_out_valid/ready    : fir_filter output handshake (drain monitor)
//   o_coef                   : active bank, packed
module fir_coef_ctrl
    import fir_ctrl_pkg::*;
#(
    parameter int N_TAPS   = 16,
    parameter int COEF_W   = 16,
    parameter int PIPE_LAT = 3,
    parameter int ADDR_W   = $clog2(N_TAPS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_cfg_wr,
    input  logic [ADDR_W-1:0]         i_cfg_addr,
    input  logic [COEF_W-1:0]         i_cfg_data,
    input  logic                      i_cfg_commit,
    output logic                      o_cfg_busy,
    output logic                      o_cfg_err,
    output logic                      o_cfg_done,
    output logic [GEN_W-1:0]          o_coef_gen,
    input  logic                      i_s_valid,
    output logic                      o_s_ready,
    output logic                      o_fir_valid,
    input  logic                      i_fir_ready,
    input  logic                      i_fir_out_valid,
    input  logic                      i_fir_out_ready,
    output logic [N_TAPS*COEF_W-1:0]  o_coef
);

    localparam int CNT_W = (PIPE_LAT < 1) ? 1 : $clog2(PIPE_LAT + 1);

    fir_ctrl_state_e   state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt, cnt_dec;
    logic [GEN_W-1:0]  gen;
    logic              held_out;
    logic              bank_wr;
    logic              bank_load;

    assign held_out   = i_fir_out_valid & ~i_fir_out_ready;
    assign cnt_dec    = (cnt == '0) ? '0 : cnt - CNT_W'(1);
    assign o_coef_gen = gen;

    // Exit is decided on the decremented count so DRAIN lasts exactly
    // PIPE_LAT cycles when no output is held.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        o_s_ready   = 1'b0;
        o_fir_valid = 1'b0;
        o_cfg_busy  = 1'b0;
        o_cfg_err   = 1'b0;
        o_cfg_done  = 1'b0;
        bank_wr     = 1'b0;
        bank_load   = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    o_s_ready   = i_fir_ready;
                    o_fir_valid = i_s_valid & i_fir_ready;
                    bank_wr     = i_cfg_wr;
                    if (i_cfg_commit) begin
                        state_nxt = DRAIN;
                        cnt_nxt   = CNT_W'(PIPE_LAT);
                    end
                end
                DRAIN: begin
                    o_cfg_busy = 1'b1;
                    o_cfg_err  = i_cfg_wr | i_cfg_commit;
                    cnt_nxt    = cnt_dec;
                    if ((cnt_dec == '0) && !held_out) begin
                        state_nxt = SWAP;
                    end
                end
                SWAP: begin
                    o_cfg_busy = 1'b1;
                    o_cfg_err  = i_cfg_wr | i_cfg_commit;
                    o_cfg_done = 1'b1;
                    bank_load  = 1'b1;
                    state_nxt  = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            gen   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (bank_load) begin
                gen <= gen + GEN_W'(1);
            end
        end
    end

    fir_coef_bank #(
        .N_TAPS (N_TAPS),
        .COEF_W (COEF_W),
        .ADDR_W (ADDR_W)
    ) u_bank (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (bank_wr),
        .wr_addr (i_cfg_addr),
        .wr_data (i_cfg_data),
        .load    (bank_load),
        .coef    (o_coef)
    );

endmodule

// File: tb/tb_fir_coef_ctrl.sv
module tb_fir_coef_ctrl;
    import fir_ctrl_pkg::*;

    localparam int NT = 16;
    localparam int CW = 16;
    localparam int PL = 3;
    localparam int AW = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              i_cfg_wr = 1'b0;
    logic [AW-1:0]     i_cfg_addr = '0;
    logic [CW-1:0]     i_cfg_data = '0;
    logic              i_cfg_commit = 1'b0;
    logic              o_cfg_busy, o_cfg_err, o_cfg_done;
    logic [7:0]        o_coef_gen;
    logic              i_s_valid = 1'b0;
    logic              o_s_ready, o_fir_valid;
    logic              i_fir_ready = 1'b0;
    logic              i_fir_out_valid = 1'b0;
    logic              i_fir_out_ready = 1'b1;
    logic [NT*CW-1:0]  o_coef;

    always #5 clk = ~clk;

    fir_coef_ctrl #(.N_TAPS(NT), .COEF_W(CW), .PIPE_LAT(PL)) dut (
        .clk(clk), .rst(rst),
        .i_cfg_wr(i_cfg_wr), .i_cfg_addr(i_cfg_addr), .i_cfg_data(i_cfg_data),
        .i_cfg_commit(i_cfg_commit), .o_cfg_busy(o_cfg_busy), .o_cfg_err(o_cfg_err),
        .o_cfg_done(o_cfg_done), .o_coef_gen(o_coef_gen),
        .i_s_valid(i_s_valid), .o_s_ready(o_s_ready), .o_fir_valid(o_fir_valid),
        .i_fir_ready(i_fir_ready), .i_fir_out_valid(i_fir_out_valid),
        .i_fir_out_ready(i_fir_out_ready), .o_coef(o_coef)
    );

    int errors = 0;
    int checks = 0;
    int err_pulses = 0;

    // Reference model: banks as plain arrays, a commit tracked as
    // "cycles spent draining" plus a pending-swap flag.
    coef_t m_shadow [NT];
    coef_t m_active [NT];
    int    m_gen = 0;
    bit    m_busy = 0;
    int    m_age = 0;
    bit    m_swap = 0;
    bit    regs_known = 0;

    task automatic chk(input string tag, input logic [NT*CW-1:0] obs, input logic [NT*CW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NT*CW-1:0] packed_active();
        logic [NT*CW-1:0] v;
        v = '0;
        for (int k = 0; k < NT; k++) v[k*CW +: CW] = m_active[k];
        return v;
    endfunction

    // One clock cycle: compare outputs against the model for the inputs now
    // applied, then advance the model across the clock edge.
    task automatic tick();
        bit busy_now;
        #1;
        busy_now = m_busy && !rst;
        if (rst) begin
            chk("s_ready", o_s_ready, 0);
            chk("fir_valid", o_fir_valid, 0);
            chk("err", o_cfg_err, 0);
            chk("done", o_cfg_done, 0);
            chk("busy", o_cfg_busy, 0);
        end else if (!m_busy) begin
            chk("s_ready", o_s_ready, i_fir_ready);
            chk("fir_valid", o_fir_valid, i_s_valid & i_fir_ready);
            chk("err", o_cfg_err, 0);
            chk("done", o_cfg_done, 0);
            chk("busy", o_cfg_busy, 0);
        end else begin
            chk("s_ready", o_s_ready, 0);
            chk("fir_valid", o_fir_valid, 0);
            chk("err", o_cfg_err, i_cfg_wr | i_cfg_commit);
            chk("done", o_cfg_done, m_swap);
            chk("busy", o_cfg_busy, 1);
        end
        if (regs_known) begin
            chk("gen", o_coef_gen, m_gen[7:0]);
            chk("coef", o_coef, packed_active());
        end
        if (o_cfg_err === 1'b1) err_pulses++;
        @(posedge clk);
        if (rst) begin
            for (int k = 0; k < NT; k++) begin
                m_shadow[k] = '0;
                m_active[k] = '0;
            end
            m_gen = 0; m_busy = 0; m_swap = 0; m_age = 0;
            regs_known = 1;
        end else if (!busy_now) begin
            if (i_cfg_wr && int'(i_cfg_addr) < NT) m_shadow[i_cfg_addr] = i_cfg_data;
            if (i_cfg_commit) begin
                m_busy = 1; m_age = 0; m_swap = 0;
            end
        end else if (m_swap) begin
            for (int k = 0; k < NT; k++) m_active[k] = m_shadow[k];
            m_gen = (m_gen + 1) % 256;
            m_busy = 0; m_swap = 0;
        end else begin
            m_age++;
            if (m_age >= PL && !(i_fir_out_valid && !i_fir_out_ready)) m_swap = 1;
        end
        #1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20; i++) begin
            if (!o_cfg_busy) break;
            tick();
        end
        chk("idle_timeout", o_cfg_busy, 0);
    endtask

    task automatic commit_once();
        i_cfg_commit = 1'b1;
        tick();
        i_cfg_commit = 1'b0;
        tick();
        wait_idle();
    endtask

    initial begin
        int stall;
        int done_at;
        logic [NT*CW-1:0] snap;
        @(posedge clk);
        #1;

        // Reset with stream valid
        rst = 1'b1; i_s_valid = 1'b1; i_fir_ready = 1'b1;
        tick();
        tick();
        chk("rst_coef", o_coef, '0);
        chk("rst_gen", o_coef_gen, 0);
        rst = 1'b0;
        #1;
        chk("first_idle_ready", o_s_ready, 1);
        tick();

        // Load taps k+1 and commit while streaming
        for (int k = 0; k < NT; k++) begin
            i_cfg_wr = 1'b1; i_cfg_addr = AW'(k); i_cfg_data = CW'(k + 1);
            tick();
        end
        i_cfg_wr = 1'b0;
        i_cfg_commit = 1'b1;
        tick();
        i_cfg_commit = 1'b0;
        stall = 0; done_at = -1;
        for (int i = 0; i < 20; i++) begin
            if (o_s_ready) break;
            stall++;
            if (o_cfg_done) done_at = stall;
            tick();
        end
        chk("stall_len", stall, 4);
        chk("done_cycle", done_at, 4);
        snap = o_coef;
        chk("tap5", snap[5*CW +: CW], 6);
        chk("gen_after_load", o_coef_gen, 1);

        // Write and commit in the same cycle
        i_cfg_wr = 1'b1; i_cfg_addr = 3; i_cfg_data = CW'(-7); i_cfg_commit = 1'b1;
        tick();
        i_cfg_wr = 1'b0; i_cfg_commit = 1'b0;
        wait_idle();
        snap = o_coef;
        chk("tap3_wr_commit", snap[3*CW +: CW], 16'hFFF9);
        chk("gen_after_wc", o_coef_gen, 2);

        // Busy rejection: write in DRAIN cycle 1, commit in SWAP
        err_pulses = 0;
        i_cfg_commit = 1'b1;
        tick();
        i_cfg_commit = 1'b0;
        i_cfg_wr = 1'b1; i_cfg_addr = 0; i_cfg_data = 16'd999;
        tick();
        i_cfg_wr = 1'b0;
        tick();
        tick();
        chk("in_swap", o_cfg_done, 1);
        i_cfg_commit = 1'b1;
        tick();
        i_cfg_commit = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("err_pulses", err_pulses, 2);
        chk("busy_after_reject", o_cfg_busy, 0);
        chk("gen_no_second_swap", o_coef_gen, 3);
        snap = o_coef;
        chk("tap0_unchanged", snap[0 +: CW], 1);

        // Output backpressure holds DRAIN
        i_cfg_commit = 1'b1;
        tick();
        i_cfg_commit = 1'b0;
        i_fir_out_valid = 1'b1;
        stall = 0;
        for (int i = 0; i < 30; i++) begin
            if (o_s_ready) break;
            stall++;
            i_fir_out_ready = (stall >= 8);
            tick();
        end
        i_fir_out_valid = 1'b0; i_fir_out_ready = 1'b1;
        chk("bp_stall_len", stall, 9);
        chk("gen_after_bp", o_coef_gen, 4);

        // Generation counter wrap
        for (int i = 0; i < 252; i++) commit_once();
        chk("gen_wrap", o_coef_gen, 0);
        commit_once();
        chk("gen_after_wrap", o_coef_gen, 1);

        // Reset during DRAIN
        i_cfg_commit = 1'b1;
        tick();
        i_cfg_commit = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("midrst_busy", o_cfg_busy, 0);
        chk("midrst_coef", o_coef, '0);
        chk("midrst_gen", o_coef_gen, 0);
        tick();

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            rst             = ($urandom_range(0, 199) == 0);
            i_cfg_wr        = ($urandom_range(0, 2) == 0);
            i_cfg_addr      = AW'($urandom_range(0, NT - 1));
            i_cfg_data      = CW'($urandom);
            i_cfg_commit    = ($urandom_range(0, 14) == 0);
            i_s_valid       = $urandom_range(0, 1);
            i_fir_ready     = ($urandom_range(0, 3) != 0);
            i_fir_out_valid = $urandom_range(0, 1);
            i_fir_out_ready = ($urandom_range(0, 2) != 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
